// File: rtl/rotary_counter.sv
// Up/down detent counter with an Avalon-MM register slave and a level irq.
// Count and flags update one cycle after an event; reads have fixed 1-cycle latency, no wait states, no backpressure.
module rotary_counter #(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             rotary_cw,
  input  logic             rotary_ccw,
  output logic [WIDTH-1:0] count,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam int          EW         = WIDTH + 9;
  localparam logic [31:0] ID_VALUE   = 32'h524F_5400 | 32'(WIDTH);
  localparam logic [1:0]  ADDR_COUNT = 2'd0;
  localparam logic [1:0]  ADDR_CTRL  = 2'd1;
  localparam logic [1:0]  ADDR_STAT  = 2'd2;
  localparam logic [1:0]  ADDR_ID    = 2'd3;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             irq_en_q, irq_en_d;
  logic [7:0]       step_q, step_d;
  logic             cw_seen_q, cw_seen_d;
  logic             ccw_seen_q, ccw_seen_d;
  logic             limit_q, limit_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [EW-1:0]    sum, diff;
  logic             over, under;
  logic             cw_only, ccw_only;
  logic [WIDTH-1:0] ev_count;
  logic             ev_limit;
  logic             wr_count, wr_ctrl;
  logic [2:0]       clr_mask;
  logic             lint_unused;

  always_comb begin
    sum  = EW'(count_q) + EW'(step_q);
    diff = EW'(count_q) - EW'(step_q);
    // step never exceeds 255, so any carry lands above WIDTH and a borrow sets the top bit
    over  = |sum[EW-1:WIDTH];
    under = diff[EW-1];
  end

  always_comb begin
    cw_only  = rotary_cw & ~rotary_ccw;
    ccw_only = rotary_ccw & ~rotary_cw;
    ev_count = count_q;
    ev_limit = 1'b0;
    if (step_q != 8'd0) begin
      if (cw_only) begin
        if (over) begin
          ev_limit = 1'b1;
          ev_count = wrap_q ? sum[WIDTH-1:0] : {WIDTH{1'b1}};
        end else begin
          ev_count = sum[WIDTH-1:0];
        end
      end else if (ccw_only) begin
        if (under) begin
          ev_limit = 1'b1;
          ev_count = wrap_q ? diff[WIDTH-1:0] : {WIDTH{1'b0}};
        end else begin
          ev_count = diff[WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    wr_count   = avs_write && (avs_address == ADDR_COUNT);
    wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
    clr_mask   = (avs_write && (avs_address == ADDR_STAT)) ? avs_writedata[2:0] : 3'b000;

    // a bus write to COUNT overrides the event result and suppresses limit evaluation
    count_d    = wr_count ? avs_writedata[WIDTH-1:0] : ev_count;
    wrap_d     = wr_ctrl ? avs_writedata[0]    : wrap_q;
    irq_en_d   = wr_ctrl ? avs_writedata[1]    : irq_en_q;
    step_d     = wr_ctrl ? avs_writedata[15:8] : step_q;

    // set beats clear when an event and a write-1-to-clear coincide
    cw_seen_d  = (cw_seen_q  & ~clr_mask[0]) | rotary_cw;
    ccw_seen_d = (ccw_seen_q & ~clr_mask[1]) | rotary_ccw;
    limit_d    = (limit_q    & ~clr_mask[2]) | (ev_limit & ~wr_count);

    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_COUNT: rdata_d = 32'(count_q);
        ADDR_CTRL:  rdata_d = {16'd0, step_q, 6'd0, irq_en_q, wrap_q};
        ADDR_STAT:  rdata_d = {29'd0, limit_q, ccw_seen_q, cw_seen_q};
        ADDR_ID:    rdata_d = ID_VALUE;
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      count_q    <= WIDTH'(RESET_VALUE);
      wrap_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      step_q     <= 8'd1;
      cw_seen_q  <= 1'b0;
      ccw_seen_q <= 1'b0;
      limit_q    <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      irq_en_q   <= irq_en_d;
      step_q     <= step_d;
      cw_seen_q  <= cw_seen_d;
      ccw_seen_q <= ccw_seen_d;
      limit_q    <= limit_d;
      rdata_q    <= rdata_d;
    end
  end

  assign count        = count_q;
  assign avs_readdata = rdata_q;
  assign irq          = irq_en_q & (cw_seen_q | ccw_seen_q | limit_q);
  assign lint_unused  = ^{avs_writedata[31:16], diff[EW-2:WIDTH]};

endmodule

// File: tb/tb_rotary_counter.sv
// Bench for rotary_counter: table-driven event vectors plus hand sequences; bus reads are scoreboarded.
module tb_rotary_counter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        rotary_cw = 1'b0;
  logic        rotary_ccw = 1'b0;
  logic [7:0]  count;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        rd_pend;

  localparam logic [31:0] ID_EXP = 32'h524F_5408;

  rotary_counter #(.WIDTH(8), .RESET_VALUE(0)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .rotary_cw(rotary_cw), .rotary_ccw(rotary_ccw), .count(count),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) rd_pend <= 1'b0;
    else                rd_pend <= avs_read;

  always @(negedge clk_clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL readdata: unexpected read completion, got 0x%08h", avs_readdata);
      end else begin
        check("readdata", avs_readdata, exp_q.pop_front());
      end
    end
  end

  task automatic cycle();
    @(negedge clk_clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    cycle();
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
    avs_read = 1'b1; avs_address = a;
    exp_q.push_back(exp);
    cycle();
    avs_read = 1'b0;
  endtask

  task automatic pulse(input logic cw, input logic ccw);
    rotary_cw = cw; rotary_ccw = ccw;
    cycle();
    rotary_cw = 1'b0; rotary_ccw = 1'b0;
  endtask

  typedef struct {
    logic        wr_count;
    logic [7:0]  count_val;
    logic        wr_ctrl;
    logic [31:0] ctrl_val;
    logic        clr;
    logic        cw;
    logic        ccw;
    logic [7:0]  exp_count;
    logic [2:0]  exp_status;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 8'h01, 3'h1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 8'h02, 3'h1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 8'h03, 3'h1};
    tbl[3]  = '{1'b1, 8'hFE, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 8'hFF, 3'h1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 8'hFF, 3'h5};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 8'hFF, 3'h5};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 32'h101, 1'b0, 1'b1, 1'b0, 8'h00, 3'h5};
    tbl[7]  = '{1'b1, 8'h02, 1'b1, 32'h401, 1'b1, 1'b0, 1'b1, 8'hFE, 3'h6};
    tbl[8]  = '{1'b1, 8'h10, 1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 8'h10, 3'h3};
    tbl[9]  = '{1'b1, 8'h10, 1'b1, 32'h000, 1'b1, 1'b1, 1'b0, 8'h10, 3'h1};
    tbl[10] = '{1'b1, 8'h00, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 8'h00, 3'h6};
    tbl[11] = '{1'b1, 8'h05, 1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 8'h02, 3'h2};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 8'h00, 3'h6};
    tbl[13] = '{1'b1, 8'hFD, 1'b1, 32'h801, 1'b1, 1'b1, 1'b0, 8'h05, 3'h5};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 8'hFD, 3'h7};

    #12;
    check("reset count", 32'(count), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    check("reset readdata", avs_readdata, 32'h0);
    cycle();
    reset_reset_n = 1'b1;
    cycle();
    bus_read(2'd2, 32'h0);
    bus_read(2'd1, 32'h0000_0100);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].wr_count) bus_write(2'd0, 32'(tbl[i].count_val));
      if (tbl[i].wr_ctrl)  bus_write(2'd1, tbl[i].ctrl_val);
      if (tbl[i].clr)      bus_write(2'd2, 32'h7);
      pulse(tbl[i].cw, tbl[i].ccw);
      check($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].exp_count));
      bus_read(2'd2, 32'(tbl[i].exp_status));
    end

    // write-1-to-clear of limit_hit only
    bus_write(2'd1, 32'h401);
    bus_write(2'd0, 32'h02);
    bus_write(2'd2, 32'h7);
    pulse(1'b0, 1'b1);
    check("w1c count", 32'(count), 32'hFE);
    bus_read(2'd2, 32'h6);
    bus_write(2'd2, 32'h4);
    bus_read(2'd2, 32'h2);

    // COUNT write coincident with cw: write wins, cw_seen still set
    bus_write(2'd1, 32'h100);
    bus_write(2'd2, 32'h7);
    avs_write = 1'b1; avs_address = 2'd0; avs_writedata = 32'h55; rotary_cw = 1'b1;
    cycle();
    avs_write = 1'b0; rotary_cw = 1'b0;
    check("wr+cw count", 32'(count), 32'h55);
    bus_read(2'd2, 32'h1);

    // read and write together returns the pre-write value
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 2'd0; avs_writedata = 32'h66;
    exp_q.push_back(32'h55);
    cycle();
    avs_read = 1'b0; avs_write = 1'b0;
    check("rd+wr count", 32'(count), 32'h66);

    // read of COUNT with a same-cycle cw returns the old value
    avs_read = 1'b1; avs_address = 2'd0; rotary_cw = 1'b1;
    exp_q.push_back(32'h66);
    cycle();
    avs_read = 1'b0; rotary_cw = 1'b0;
    check("rd+cw count", 32'(count), 32'h67);

    bus_read(2'd3, ID_EXP);
    bus_write(2'd3, 32'hFFFF_FFFF);
    cycle(); cycle();
    check("readdata hold", avs_readdata, ID_EXP);
    bus_read(2'd3, ID_EXP);

    // interrupt behaviour
    bus_write(2'd0, 32'h20);
    bus_write(2'd1, 32'h102);
    bus_write(2'd2, 32'h7);
    check("irq idle", 32'(irq), 32'h0);
    pulse(1'b0, 1'b1);
    check("irq ccw count", 32'(count), 32'h1F);
    check("irq after ccw", 32'(irq), 32'h1);
    avs_write = 1'b1; avs_address = 2'd2; avs_writedata = 32'h7; rotary_cw = 1'b1;
    cycle();
    avs_write = 1'b0; rotary_cw = 1'b0;
    check("irq set beats clear", 32'(irq), 32'h1);
    check("set/clr count", 32'(count), 32'h20);
    bus_read(2'd2, 32'h1);
    bus_write(2'd2, 32'h7);
    check("irq cleared", 32'(irq), 32'h0);

    // asynchronous reset between clock edges
    pulse(1'b1, 1'b0);
    check("pre-reset irq", 32'(irq), 32'h1);
    bus_read(2'd3, ID_EXP);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check("async count", 32'(count), 32'h0);
    check("async irq", 32'(irq), 32'h0);
    check("async readdata", avs_readdata, 32'h0);
    cycle();
    reset_reset_n = 1'b1;
    cycle();
    bus_read(2'd2, 32'h0);
    bus_read(2'd1, 32'h0000_0100);
    bus_read(2'd3, ID_EXP);
    bus_read(2'd0, 32'h0);
    cycle(); cycle();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotary_counter.md
Name: rotary_counter

Overview:
- Consumes the single-cycle rotary_cw / rotary_ccw event pulses from the rotary controller.
- Maintains an up/down count that drives the 8-bit input of the eight-bit-to-seven-segment stage.
- Exposes an Avalon-MM slave so the Nios II can read and preset the count, set the step and wrap mode, and poll or clear event flags.
- Raises a level interrupt on selected events.

Parameters:
- WIDTH, 8, count width in bits; must be 2..16.
- RESET_VALUE, 0, count value loaded on reset; must be less than 2^WIDTH.

Ports:
- clk_clk  input  1  system clock
- reset_reset_n  input  1  asynchronous active-low reset
- rotary_cw  input  1  one-cycle pulse, clockwise detent
- rotary_ccw  input  1  one-cycle pulse, counter-clockwise detent
- count  output  WIDTH  current count, to the seven-seg converter
- avs_address  input  2  word address
- avs_read  input  1  read strobe
- avs_write  input  1  write strobe
- avs_writedata  input  32  write data
- avs_readdata  output  32  read data, valid one cycle after avs_read
- irq  output  1  level interrupt, active high

Behaviour:
- Reset is asynchronous, active-low. On reset:
  - count=RESET_VALUE, CONTROL=0x0000_0100 (step=1, wrap=0, irq_en=0).
  - STATUS=0, avs_readdata=0, irq=0.
- Register map:
  - 0 COUNT, R/W: bits WIDTH-1:0, upper bits read 0.
  - 1 CONTROL, R/W: bit0 wrap_en, bit1 irq_en, bits 15:8 step. Other bits read 0.
  - 2 STATUS, read / write-1-to-clear: bit0 cw_seen, bit1 ccw_seen, bit2 limit_hit.
  - 3 ID, read-only: returns 0x524F_5400 | WIDTH. Writes are ignored.
- Event handling, registered; count updates the cycle after the pulse:
  - cw only: next = count+step.
  - ccw only: next = count-step.
  - Arithmetic is done in WIDTH+9 bits.
  - wrap_en=1: result modulo 2^WIDTH; limit_hit is set if the true result left 0..2^WIDTH-1.
  - wrap_en=0: result clamps to 2^WIDTH-1 or 0; limit_hit is set if clamping occurred or count was already at the limit.
  - cw_seen / ccw_seen are set on the respective pulse.
  - cw and ccw in the same cycle: count unchanged, limit_hit unchanged, both cw_seen and ccw_seen set.
  - step=0: count unchanged; cw/ccw flags still set; limit_hit not set.
- Bus write to COUNT in the same cycle as an event:
  - The write wins; count takes avs_writedata[WIDTH-1:0].
  - The event's cw/ccw flags are still set; limit_hit is not evaluated.
- STATUS write:
  - Clears the bits written as 1.
  - A flag set by an event in the same cycle stays set (set beats clear).
- Bus timing:
  - Reads have fixed 1-cycle latency with no wait states.
  - avs_readdata holds its value until the next read.
  - A read of COUNT returns the value before any same-cycle update.
  - Read and write asserted together: the write is performed and the read returns the pre-write value.
- irq = irq_en AND (cw_seen OR ccw_seen OR limit_hit), combinational from registers.
- The count output is a direct register output, never glitching mid-cycle.

Test Plan:
1. Reset, then 3 cw pulses with step=1 -> count 0,1,2,3 each one cycle after its pulse; STATUS reads 0x1.
2. Write COUNT=0xFE, wrap_en=0, 3 cw pulses -> count 0xFF, 0xFF, 0xFF; limit_hit=1. Then set wrap_en=1, 1 cw -> count 0x00, limit_hit remains 1.
3. Write CONTROL=0x0000_0401 (step 4, wrap), COUNT=0x02, 1 ccw -> count 0xFE; STATUS=0x6. Write STATUS=0x4 -> STATUS=0x2.
4. cw and ccw in the same cycle at count 0x10 -> count stays 0x10; STATUS=0x3. Also: COUNT write of 0x55 coincident with a cw pulse -> count 0x55, cw_seen=1.
5. irq_en=1 with STATUS clear, 1 ccw -> irq rises the cycle after the pulse. Write STATUS=0x7 in the same cycle as a new cw -> cw_seen stays 1, irq stays 1. Then clear STATUS -> irq 0.
6. Assert reset_reset_n low asynchronously mid-count, between clock edges -> count, STATUS and irq drop to reset values immediately; ID reads 0x524F_5408.
